// File: rtl/vga_bounce_circle.sv
// vga_bounce_circle: VGA timing, pipelined filled-circle renderer and bouncing motion engine
// Ports:
//   PixClk, Rst          pixel clock, asynchronous active-high reset
//   Radius, Step, Pause  circle radius, per-frame step on each axis, motion freeze
//   Colour               circle colour, RGB 3:3:2
//   Hsync, Vsync         sync outputs, delayed two cycles to line up with RGB
//   Red, Green, Blue     pixel colour
//   Hcounter, Vcounter   raw (undelayed) timing counters
//   FrameTick            one-cycle pulse at the start of the first blanking line
//   Led                  Led[0] blinks from a free-running counter, Led[7:1] = 0
module vga_bounce_circle #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int R_W      = 8,
  parameter int STEP_W   = 4,
  parameter int BLINK_W  = 21
) (
  input  logic              PixClk,
  input  logic              Rst,
  input  logic [R_W-1:0]    Radius,
  input  logic [STEP_W-1:0] Step,
  input  logic              Pause,
  input  logic [7:0]        Colour,
  output logic              Hsync,
  output logic              Vsync,
  output logic [2:0]        Red,
  output logic [2:0]        Green,
  output logic [1:0]        Blue,
  output logic [9:0]        Hcounter,
  output logic [9:0]        Vcounter,
  output logic              FrameTick,
  output logic [7:0]        Led
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_TICK = 10'(V_ACTIVE);
  // 11-bit bounds so a sync pulse ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_ON  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_OFF = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_ON  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_OFF = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        IDLE   = (SYNC_POL == 0);

  logic [9:0]         h, v;
  logic [9:0]         cx, cy;
  logic               dir_x, dir_y;
  logic [R_W-1:0]     r_lat;
  logic [7:0]         col_lat;
  logic [9:0]         adx, ady;
  logic               act1, hs1, vs1;
  logic               hs_raw, vs_raw, act_raw;
  logic [20:0]        dist_sq, r_sq;
  logic [10:0]        nx, ny;
  logic [BLINK_W-1:0] blink;

  // Returns {direction, centre} for one axis after a frame step.
  // Direction 1 means moving towards larger coordinates.
  function automatic logic [10:0] axis_next(input logic [9:0] c, input logic pos,
                                            input int r, input int s, input int act);
    int ci, lim;
    ci  = int'(c);
    lim = act - 1 - r;
    if (2 * r >= act) return {pos, 10'(act / 2)};
    if (pos) return (ci + s >= lim) ? {1'b0, 10'(lim)} : {1'b1, 10'(ci + s)};
    return (ci <= r + s) ? {1'b1, 10'(r)} : {1'b0, 10'(ci - s)};
  endfunction

  assign Hcounter  = h;
  assign Vcounter  = v;
  assign FrameTick = (h == 10'd0) && (v == V_TICK);
  assign Led       = {7'd0, blink[BLINK_W-1]};

  assign act_raw = ({1'b0, h} < H_ACT) && ({1'b0, v} < V_ACT);
  assign hs_raw  = ({1'b0, h} >= HS_ON && {1'b0, h} < HS_OFF) ? ~IDLE : IDLE;
  assign vs_raw  = ({1'b0, v} >= VS_ON && {1'b0, v} < VS_OFF) ? ~IDLE : IDLE;

  assign dist_sq = 21'(adx) * 21'(adx) + 21'(ady) * 21'(ady);
  assign r_sq    = 21'(r_lat) * 21'(r_lat);

  // Motion uses the radius being latched this tick so a larger radius is clamped at once
  assign nx = axis_next(cx, dir_x, int'(Radius), int'(Step), H_ACTIVE);
  assign ny = axis_next(cy, dir_y, int'(Radius), int'(Step), V_ACTIVE);

  always_ff @(posedge PixClk or posedge Rst) begin
    if (Rst) begin
      h <= '0;
      v <= '0;
    end else begin
      h <= (h == H_LAST) ? '0 : h + 10'd1;
      if (h == H_LAST) v <= (v == V_LAST) ? '0 : v + 10'd1;
    end
  end

  // Stage 1: distances from the centre, active flag and raw sync levels
  always_ff @(posedge PixClk or posedge Rst) begin
    if (Rst) begin
      adx  <= '0;
      ady  <= '0;
      act1 <= 1'b0;
      hs1  <= IDLE;
      vs1  <= IDLE;
    end else begin
      adx  <= (h >= cx) ? h - cx : cx - h;
      ady  <= (v >= cy) ? v - cy : cy - v;
      act1 <= act_raw;
      hs1  <= hs_raw;
      vs1  <= vs_raw;
    end
  end

  // Stage 2: inside test and colour, syncs kept in step with the pixel
  always_ff @(posedge PixClk or posedge Rst) begin
    if (Rst) begin
      {Red, Green, Blue} <= 8'h00;
      Hsync              <= IDLE;
      Vsync              <= IDLE;
    end else begin
      {Red, Green, Blue} <= (act1 && dist_sq <= r_sq) ? col_lat : 8'h00;
      Hsync              <= hs1;
      Vsync              <= vs1;
    end
  end

  // Frame update happens in vertical blanking, so the visible image never tears
  always_ff @(posedge PixClk or posedge Rst) begin
    if (Rst) begin
      cx      <= 10'(H_ACTIVE / 2);
      cy      <= 10'(V_ACTIVE / 2);
      dir_x   <= 1'b1;
      dir_y   <= 1'b1;
      r_lat   <= '0;
      col_lat <= '0;
    end else if (FrameTick) begin
      r_lat   <= Radius;
      col_lat <= Colour;
      if (!Pause) begin
        {dir_x, cx} <= nx;
        {dir_y, cy} <= ny;
      end
    end
  end

  always_ff @(posedge PixClk or posedge Rst) begin
    if (Rst) blink <= '0;
    else     blink <= blink + 1'b1;
  end
endmodule

// File: tb/tb_vga_bounce_circle.sv
// tb_vga_bounce_circle: randomized self-checking bench against a pixel-level reference model
module tb_vga_bounce_circle;
  localparam int HA = 48, HFP = 2, HS = 4, HBP = 2;
  localparam int VA = 36, VFP = 2, VS = 2, VBP = 2;
  localparam int BW = 6;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam logic [38:0] IDLE_ALL = {10'd0, 10'd0, 1'b1, 1'b1, 8'd0, 1'b0, 8'd0};

  logic       PixClk = 1'b0;
  logic       Rst = 1'b1;
  logic [7:0] Radius = 8'd0;
  logic [3:0] Step = 4'd0;
  logic       Pause = 1'b1;
  logic [7:0] Colour = 8'd0;
  logic       Hsync, Vsync, FrameTick;
  logic [2:0] Red, Green;
  logic [1:0] Blue;
  logic [9:0] Hcounter, Vcounter;
  logic [7:0] Led;
  logic [38:0] got, e_all;

  int vectors = 0;
  int errors = 0;

  int n, mcx, mcy, mdx, mdy, mr;
  logic [7:0] mcol;
  logic [7:0] p_rgb [2];
  logic       p_hs [2];
  logic       p_vs [2];

  vga_bounce_circle #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(0), .R_W(8), .STEP_W(4), .BLINK_W(BW)
  ) dut (
    .PixClk(PixClk), .Rst(Rst), .Radius(Radius), .Step(Step), .Pause(Pause),
    .Colour(Colour), .Hsync(Hsync), .Vsync(Vsync), .Red(Red), .Green(Green),
    .Blue(Blue), .Hcounter(Hcounter), .Vcounter(Vcounter), .FrameTick(FrameTick),
    .Led(Led)
  );

  always #5 PixClk = ~PixClk;

  assign got = {Hcounter, Vcounter, Hsync, Vsync, Red, Green, Blue, FrameTick, Led};

  function automatic int bounce(input int c, input int dir, input int r, input int s,
                                input int act, output int nd);
    nd = dir;
    if (2 * r >= act) return act / 2;
    if (dir > 0 && c + s >= act - 1 - r) begin nd = -1; return act - 1 - r; end
    if (dir > 0) return c + s;
    if (c <= r + s) begin nd = 1; return r; end
    return c - s;
  endfunction

  function automatic int disc(input int cx, input int cy, input int r);
    int c = 0;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        if ((x - cx) * (x - cx) + (y - cy) * (y - cy) <= r * r) c++;
    return c;
  endfunction

  // Reference model: position from the cycle count, outputs delayed two pixels
  always @(negedge PixClk) begin
    int h, v, nd;
    if (Rst) begin
      n = 0; mcx = HA / 2; mcy = VA / 2; mdx = 1; mdy = 1; mr = 0; mcol = 8'd0;
      p_rgb[0] = 8'd0; p_rgb[1] = 8'd0;
      p_hs[0] = 1'b1; p_hs[1] = 1'b1; p_vs[0] = 1'b1; p_vs[1] = 1'b1;
      e_all = IDLE_ALL;
    end else begin
      h = n % HT;
      v = (n / HT) % VT;
      e_all = {10'(h), 10'(v), p_hs[1], p_vs[1], p_rgb[1], (h == 0 && v == VA), 7'd0, n[BW-1]};
      p_rgb[1] = p_rgb[0]; p_hs[1] = p_hs[0]; p_vs[1] = p_vs[0];
      p_rgb[0] = (h < HA && v < VA &&
                  (h - mcx) * (h - mcx) + (v - mcy) * (v - mcy) <= mr * mr) ? mcol : 8'h00;
      p_hs[0] = !(h >= HA + HFP && h < HA + HFP + HS);
      p_vs[0] = !(v >= VA + VFP && v < VA + VFP + VS);
      if (h == 0 && v == VA) begin
        mr = int'(Radius);
        mcol = Colour;
        if (!Pause) begin
          mcx = bounce(mcx, mdx, mr, int'(Step), HA, nd); mdx = nd;
          mcy = bounce(mcy, mdy, mr, int'(Step), VA, nd); mdy = nd;
        end
      end
      n++;
    end
  end

  task test_reset;
    @(posedge PixClk); #1 Rst = 1'b1;
    repeat (3) @(posedge PixClk);
    @(negedge PixClk); #1;
    vectors++;
    if (got !== IDLE_ALL) begin errors++; $display("FAIL reset got=%h exp=%h", got, IDLE_ALL); end
    @(posedge PixClk); #1 Rst = 1'b0;
  endtask

  task test_timing;
    int hs_low, hs_win, vs_low, ticks;
    hs_low = 0; hs_win = 0; vs_low = 0; ticks = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      @(negedge PixClk); #1;
      vectors++;
      if (got !== e_all) begin errors++; $display("FAIL timing n=%0d got=%h exp=%h", n, got, e_all); end
      if (!Hsync) hs_low++;
      if (!Hsync && Hcounter >= HA + HFP + 2 && Hcounter < HA + HFP + HS + 2) hs_win++;
      if (!Vsync) vs_low++;
      if (FrameTick) ticks++;
    end
    vectors++;
    if (hs_low !== 2 * HS * VT) begin errors++; $display("FAIL hsync_len got=%0d exp=%0d", hs_low, 2 * HS * VT); end
    vectors++;
    if (hs_win !== 2 * HS * VT) begin errors++; $display("FAIL hsync_pos got=%0d exp=%0d", hs_win, 2 * HS * VT); end
    vectors++;
    if (vs_low !== 2 * VS * HT) begin errors++; $display("FAIL vsync_len got=%0d exp=%0d", vs_low, 2 * VS * HT); end
    vectors++;
    if (ticks !== 2) begin errors++; $display("FAIL tick_count got=%0d exp=2", ticks); end
  endtask

  task test_pixels;
    int lit;
    lit = 0;
    @(posedge PixClk); #1 Pause = 1'b1; Radius = 8'd10; Colour = 8'hE0;
    for (int i = 0; i < 2 * FT; i++) begin
      @(negedge PixClk); #1;
      vectors++;
      if (got !== e_all) begin errors++; $display("FAIL pixels n=%0d got=%h exp=%h", n, got, e_all); end
      if (i >= FT) begin
        if (Vcounter == 18 && Hcounter >= 2 && Hcounter < HA + 2 && {Red, Green, Blue} != 8'h00) lit++;
        if ((Vcounter == 28 && Hcounter == 26) || (Vcounter == 18 && (Hcounter == 16 || Hcounter == 36))) begin
          vectors++;
          if ({Red, Green, Blue} !== 8'hE0) begin
            errors++; $display("FAIL pix_lit v=%0d h=%0d got=%h exp=e0", Vcounter, Hcounter, {Red, Green, Blue});
          end
        end
        if ((Vcounter == 29 && Hcounter == 26) || (Vcounter == 18 && (Hcounter == 15 || Hcounter == 37))) begin
          vectors++;
          if ({Red, Green, Blue} !== 8'h00) begin
            errors++; $display("FAIL pix_dark v=%0d h=%0d got=%h exp=00", Vcounter, Hcounter, {Red, Green, Blue});
          end
        end
      end
    end
    vectors++;
    if (lit !== 21) begin errors++; $display("FAIL row_width got=%0d exp=21", lit); end
    @(posedge PixClk); #1 Radius = 8'($urandom_range(1, 17)); Colour = 8'($urandom_range(1, 255));
    for (int i = 0; i < 2 * FT; i++) begin
      @(negedge PixClk); #1;
      vectors++;
      if (got !== e_all) begin errors++; $display("FAIL pixels_rand n=%0d got=%h exp=%h", n, got, e_all); end
    end
  endtask

  task test_motion;
    @(posedge PixClk); #1 Pause = 1'b0; Radius = 8'd5; Step = 4'($urandom_range(5, 9));
    Colour = 8'($urandom_range(1, 255));
    for (int i = 0; i < 6 * FT; i++) begin
      @(negedge PixClk); #1;
      vectors++;
      if (got !== e_all) begin errors++; $display("FAIL motion n=%0d got=%h exp=%h", n, got, e_all); end
    end
  endtask

  task test_radius_change;
    int lit, want, ticks;
    lit = 0; ticks = 0;
    @(posedge PixClk); #1 Pause = 1'b1; Radius = 8'd4; Colour = 8'h1C;
    for (int i = 0; i < 3 * FT + 2 && ticks < 3; i++) begin
      @(negedge PixClk); #1;
      vectors++;
      if (got !== e_all) begin errors++; $display("FAIL radius n=%0d got=%h exp=%h", n, got, e_all); end
      if (FrameTick) begin
        ticks++;
        if (ticks > 1) begin
          want = disc(mcx, mcy, (ticks == 2) ? 4 : 12);
          vectors++;
          if (lit !== want) begin errors++; $display("FAIL radius_area tick=%0d got=%0d exp=%0d", ticks, lit, want); end
        end
        lit = 0;
      end else if ({Red, Green, Blue} != 8'h00) lit++;
      if (ticks == 1 && Vcounter == 10 && Hcounter == 0) begin
        @(posedge PixClk); #1 Radius = 8'd12;
      end
    end
    vectors++;
    if (ticks !== 3) begin errors++; $display("FAIL radius_timeout got=%0d exp=3", ticks); end
  endtask

  task test_big_radius;
    int bad;
    bad = 0;
    @(posedge PixClk); #1 Pause = 1'b0; Radius = 8'd20; Step = 4'd2; Colour = 8'($urandom_range(1, 255));
    for (int i = 0; i < 2 * FT; i++) begin
      @(negedge PixClk); #1;
      vectors++;
      if (got !== e_all) begin errors++; $display("FAIL big_radius n=%0d got=%h exp=%h", n, got, e_all); end
      if ((Vcounter >= VA || Hcounter < 2 || Hcounter >= HA + 2) && {Red, Green, Blue} != 8'h00) bad++;
    end
    vectors++;
    if (bad !== 0) begin errors++; $display("FAIL blank_rgb got=%0d exp=0", bad); end
  endtask

  task test_reset_mid;
    int first;
    first = -1;
    @(posedge PixClk); #1 Pause = 1'b1; Radius = 8'd6; Colour = 8'hFF;
    for (int i = 0; i < FT + 1 && Vcounter != 10'd30; i++) begin
      @(negedge PixClk); #1;
      vectors++;
      if (got !== e_all) begin errors++; $display("FAIL pre_reset n=%0d got=%h exp=%h", n, got, e_all); end
    end
    vectors++;
    if (Vcounter !== 10'd30) begin errors++; $display("FAIL reset_wait got=%0d exp=30", Vcounter); end
    @(posedge PixClk); #1 Rst = 1'b1;
    #1;
    vectors++;
    if (got !== IDLE_ALL) begin errors++; $display("FAIL async_reset got=%h exp=%h", got, IDLE_ALL); end
    @(posedge PixClk); #1 Rst = 1'b0;
    for (int i = 0; i < 2 * FT; i++) begin
      @(negedge PixClk); #1;
      vectors++;
      if (got !== e_all) begin errors++; $display("FAIL post_reset n=%0d got=%h exp=%h", n, got, e_all); end
      if (first < 0 && Led[0]) first = i;
      if (i >= FT && Vcounter == 18 && (Hcounter == 26 || Hcounter == 32)) begin
        vectors++;
        if ({Red, Green, Blue} !== 8'hFF) begin errors++; $display("FAIL centre_lit h=%0d got=%h exp=ff", Hcounter, {Red, Green, Blue}); end
      end
      if (i >= FT && Vcounter == 18 && Hcounter == 33) begin
        vectors++;
        if ({Red, Green, Blue} !== 8'h00) begin errors++; $display("FAIL centre_dark got=%h exp=00", {Red, Green, Blue}); end
      end
    end
    vectors++;
    if (first !== 32) begin errors++; $display("FAIL led_first got=%0d exp=32", first); end
  endtask

  initial begin
    test_reset;
    test_timing;
    test_pixels;
    test_motion;
    test_radius_change;
    test_big_radius;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/vga_bounce_circle.md
Name: vga_bounce_circle

Overview:
- Parametrised successor to the fixed 640x480 circle display path.
- Combines VGA timing generation, a pipelined filled-circle renderer and a per-frame motion engine; the circle bounces off the active-area edges.
- Timing, colour, step size and LED blink rate are parameters or ports rather than constants.
- Sits between the pixel-clock generator and the board RGB/sync pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, sync asserted level (0 = active-low)
- R_W, 8, radius width
- STEP_W, 4, per-frame step width
- BLINK_W, 21, LED blink counter width

Ports:
- PixClk  in  1  pixel clock
- Rst  in  1  asynchronous active-high reset
- Radius  in  R_W  circle radius in pixels
- Step  in  STEP_W  pixels moved per frame on each axis
- Pause  in  1  1 = freeze motion
- Colour  in  8  circle colour, RGB 3:3:2
- Hsync  out  1  horizontal sync
- Vsync  out  1  vertical sync
- Red  out  3  red channel
- Green  out  3  green channel
- Blue  out  2  blue channel
- Hcounter  out  10  raw horizontal count
- Vcounter  out  10  raw vertical count
- FrameTick  out  1  one-cycle pulse at the frame update point
- Led  out  8  status LEDs

Behaviour:
- Reset (async, Rst=1):
  - Hcounter=0, Vcounter=0.
  - Hsync=Vsync=~SYNC_POL.
  - Red/Green/Blue=0, FrameTick=0, Led=0.
  - Centre=(H_ACTIVE/2, V_ACTIVE/2); direction +X,+Y.
  - Latched radius=0, latched colour=0.
- Timing counters:
  - H_TOTAL = sum of H_*; V_TOTAL = sum of V_*.
  - Hcounter wraps H_TOTAL-1 -> 0 and increments Vcounter; Vcounter wraps V_TOTAL-1 -> 0.
  - Both counters are 10 bits; H_TOTAL and V_TOTAL must be <= 1024.
  - Line/frame starts at active pixel 0.
  - Hsync asserted for H_ACTIVE+H_FP <= Hcounter < H_ACTIVE+H_FP+H_SYNC; Vsync likewise on Vcounter.
- Pixel pipeline (latency 2, cycles c+1 and c+2 after the counter value at c):
  - Stage 1 registers |Hcounter-Cx| and |Vcounter-Cy| (10 bits each) plus an active flag (H<H_ACTIVE && V<V_ACTIVE) and raw sync levels.
  - Stage 2 registers inside = (dx²+dy² <= R²), using a 21-bit sum and zero-extended R².
  - RGB = Colour if active && inside, else 0.
  - Hsync/Vsync are delayed 2 cycles so they stay aligned with RGB.
  - Hcounter/Vcounter outputs are undelayed.
- Frame update:
  - At Hcounter==0 && Vcounter==V_ACTIVE (first blanking line), FrameTick=1 for one cycle.
  - Same cycle: latch Radius and Colour; these are used for the whole next frame.
  - Mid-frame changes never tear the image.
- Motion (on FrameTick, skipped when Pause=1), per axis, with limit L = ACTIVE-1-R:
  - Positive direction: if C+Step >= L then C<=L and flip direction, else C<=C+Step.
  - Negative direction: if C <= R+Step then C<=R and flip direction, else C<=C-Step.
  - If 2R >= ACTIVE on an axis, that centre is forced to ACTIVE/2 and its direction is unchanged.
  - Step=0 still applies the clamp, so a radius increase pulls the centre inside.
- LED:
  - Free-running BLINK_W counter.
  - Led[0] = counter MSB; Led[7:1] = 0.
- Reset mid-frame: all state returns to reset values immediately; the first frame after release starts at (0,0).

Test Plan:
- Reset, run 2 frames at defaults -> frame = 800x525 = 420000 cycles.
  - Hsync low for 96 cycles starting when Hcounter=656, observed 2 cycles later.
  - Vsync low for lines 490-491.
- Pause=1, Radius=10, Colour=8'hE0, one frame -> on line 240 RGB=E0 for pixels 310..330 inclusive and 0 at 309 and 331.
  - Pixel (320,250) lit; (320,251) dark.
- Pause=0, Radius=20, Step=8 -> Cx sequence 320,328,…,616, then clamps to 619 and the X direction flips; next 611.
  - Cy clamps at 459 and then 20 symmetrically.
- Change Radius 10->40 mid-frame (line 100) -> current frame keeps r=10; r=40 takes effect only after the next FrameTick.
- Radius=255 (2R >= 480) -> Cy forced to 240, Cx still moves; no RGB output outside the active area.
- Assert Rst at line 300 -> outputs 0 or idle sync immediately, centre back to (320,240).
  - Led[0] toggles every 2^20 cycles after release.
